// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares a single uart_top TX path among NREQ
// requesters. Each requester offers a complete frame (FRAME_SIZE characters of
// DBITS bits). One requester is granted at a time: its frame is captured into
// tx_in, ack pulses for that requester, then tx_trigger pulses once. The
// arbiter then waits for uart_top to report tx_ready before granting again.
//
// Optional feature (compile-time macro UART_TX_ARB_TIMEOUT_EN):
//   Adds a DRAIN watchdog. If tx_ready stays low for TIMEOUT_CYCLES cycles
//   while draining, the arbiter returns to IDLE and sets the sticky
//   timeout_err flag. Without the macro, DRAIN waits indefinitely and
//   timeout_err is tied low.
//
// Ports:
//   clk_100MHz   in   system clock, all logic on rising edge
//   reset        in   synchronous, active-high
//   req          in   [NREQ]          level requests, held until ack
//   req_data     in   [NREQ*FBITS]    frame of requester i at [i*FBITS +: FBITS]
//   ack          out  [NREQ]          one-cycle pulse, frame captured
//   tx_ready     in                   uart_top can accept a new frame
//   tx_trigger   out                  one-cycle start pulse to uart_top
//   tx_in        out  [FBITS]         registered frame to uart_top
//   busy         out                  high in any state other than IDLE
//   grant_id     out  [$clog2(NREQ)]  current/last granted requester
//   timeout_err  out                  sticky watchdog flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DBITS         = 8,
  parameter int FRAME_SIZE    = 4,
  parameter int SETTLE_CYCLES = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                                clk_100MHz,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ*FRAME_SIZE*DBITS-1:0]    req_data,
  output logic [NREQ-1:0]                     ack,
  input  logic                                tx_ready,
  output logic                                tx_trigger,
  output logic [FRAME_SIZE*DBITS-1:0]         tx_in,
  output logic                                busy,
  output logic [$clog2(NREQ)-1:0]             grant_id,
  output logic                                timeout_err
);

  localparam int FBITS = FRAME_SIZE * DBITS;
  localparam int IDW   = $clog2(NREQ);
  localparam int SCW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG,
    ST_SETTLE,
    ST_DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [FBITS-1:0] tx_in_reg, tx_in_next;
  logic [IDW-1:0]   grant_id_reg, grant_id_next;
  logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [SCW-1:0]   settle_cnt_reg, settle_cnt_next;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int DCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [DCW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic             timeout_err_reg, timeout_err_next;
`endif

  // Per-requester frame slices.
  logic [FBITS-1:0] frame [NREQ];

  // Candidate k is the requester k places after the rr pointer (wrapping),
  // so candidate 0 has the highest priority this round.
  logic [IDW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0]  cand_req;
  logic [IDW-1:0]   winner;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [IDW:0] sum;

    assign frame[gi]    = req_data[gi*FBITS +: FBITS];
    assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                  : sum[IDW-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];

    // ack is decoded from the registered grant, so it is one-hot or zero.
    assign ack[gi] = (state_reg == ST_LOAD) && (grant_id_reg == IDW'(gi));
  end

  // Scan downwards so the lowest-numbered set candidate is the last writer.
  always_comb begin
    winner = cand_idx[0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    tx_in_next      = tx_in_reg;
    grant_id_next   = grant_id_reg;
    rr_ptr_next     = rr_ptr_reg;
    settle_cnt_next = settle_cnt_reg;
`ifdef UART_TX_ARB_TIMEOUT_EN
    drain_cnt_next   = drain_cnt_reg;
    timeout_err_next = timeout_err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (tx_ready && (|req)) begin
          state_next    = ST_LOAD;
          tx_in_next    = frame[winner];
          grant_id_next = winner;
        end
      end

      ST_LOAD: begin
        state_next = ST_TRIG;
      end

      ST_TRIG: begin
        rr_ptr_next     = (grant_id_reg == IDW'(NREQ - 1)) ? '0
                                                           : grant_id_reg + 1'b1;
        settle_cnt_next = '0;
        state_next      = ST_SETTLE;
      end

      // uart_top may take a few cycles to drop tx_ready after the trigger,
      // so tx_ready is deliberately not looked at here.
      ST_SETTLE: begin
        if (settle_cnt_reg == SCW'(SETTLE_CYCLES - 1)) begin
          state_next = ST_DRAIN;
`ifdef UART_TX_ARB_TIMEOUT_EN
          drain_cnt_next = '0;
`endif
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end

      ST_DRAIN: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        drain_cnt_next = drain_cnt_reg + 1'b1;
        if (tx_ready) begin
          state_next = ST_IDLE;
        end else if (drain_cnt_reg == DCW'(TIMEOUT_CYCLES - 1)) begin
          state_next       = ST_IDLE;
          timeout_err_next = 1'b1;
        end
`else
        if (tx_ready) begin
          state_next = ST_IDLE;
        end
`endif
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      tx_in_reg      <= '0;
      grant_id_reg   <= '0;
      rr_ptr_reg     <= '0;
      settle_cnt_reg <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      drain_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      tx_in_reg      <= tx_in_next;
      grant_id_reg   <= grant_id_next;
      rr_ptr_reg     <= rr_ptr_next;
      settle_cnt_reg <= settle_cnt_next;
`ifdef UART_TX_ARB_TIMEOUT_EN
      drain_cnt_reg   <= drain_cnt_next;
      timeout_err_reg <= timeout_err_next;
`endif
    end
  end

  assign tx_trigger = (state_reg == ST_TRIG);
  assign tx_in      = tx_in_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign grant_id   = grant_id_reg;

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
